// File: rtl/router_pkg.sv
// Shared router types: link FSM states and round-robin lane selection.
package router_pkg;

    typedef enum logic [1:0] {L_IDLE, L_REQ, L_REL} link_state_e;

    localparam int unsigned MAX_CH = 16;

    // First set bit of mask at or after ptr, wrapping at MAX_CH. Bits of mask
    // above the real lane count must be zero so the wrap lands on lane 0.
    function automatic logic [3:0] rr_next(input logic [MAX_CH-1:0] mask,
                                           input logic [3:0]        ptr);
        logic [3:0] idx;
        logic       found;
        rr_next = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            idx = ptr + 4'(i);
            if (!found && mask[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rt_lane_fifo.sv
// One input lane: 4-phase req/ack receiver feeding a DEPTH-entry circular FIFO.
module rt_lane_fifo #(
    parameter int unsigned n     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [n-1:0] data,
    output logic         ack,
    input  logic         pop,
    output logic [n-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [n-1:0] mem [DEPTH];
    logic         capture;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign capture = req && !ack && !full;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ack    <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + ONE;
                ack    <= 1'b1;
            end else if (ack && !req) begin
                ack    <= 1'b0;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

endmodule

// File: rtl/noc_link_mux.sv
// Buffered link stage: N_CH 4-phase input lanes serialised round-robin onto one tagged output.
module noc_link_mux
    import router_pkg::*;
#(
    parameter  int unsigned n     = 32,
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_req,
    output logic [N_CH-1:0]   in_ack,
    input  logic [N_CH*n-1:0] in_data,
    output logic              out_req,
    input  logic              out_ack,
    output logic [n-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [N_CH-1:0]   lane_full,
    output logic [N_CH-1:0]   lane_empty
);

    link_state_e       state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [n-1:0]      grant_head;
    logic [MAX_CH-1:0] mask;
    logic [N_CH-1:0]   pop;
    logic [n-1:0]      head [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        rt_lane_fifo #(
            .n     (n),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .req   (in_req[i]),
            .data  (in_data[i*n +: n]),
            .ack   (in_ack[i]),
            .pop   (pop[i]),
            .head  (head[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
    end

    always_comb begin
        mask           = '0;
        mask[N_CH-1:0] = ~lane_empty;
    end

    assign grant = CH_W'(rr_next(mask, 4'(rr_ptr)));

    always_comb begin
        grant_head = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant == CH_W'(i)) grant_head = head[i];
        end
    end

    // out_ch holds the granted lane for the whole L_REQ phase.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pop[i] = (state == L_REQ) && out_ack && (out_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= L_IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                L_IDLE: begin
                    if (!(&lane_empty)) begin
                        out_data <= grant_head;
                        out_ch   <= grant;
                        out_req  <= 1'b1;
                        state    <= L_REQ;
                    end
                end
                L_REQ: begin
                    if (out_ack) begin
                        out_req <= 1'b0;
                        rr_ptr  <= (out_ch == CH_W'(N_CH - 1)) ? '0 : out_ch + 1'b1;
                        state   <= L_REL;
                    end
                end
                L_REL: begin
                    if (!out_ack) state <= L_IDLE;
                end
                default: state <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_link_mux.sv
// Random and directed stimulus on three link configurations, checked against a queue-based model.
module tb_noc_link_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT0: 4 lanes x 4 deep
    logic [3:0]   req0, ack0, full0, empty0;
    logic [127:0] data0;
    logic         oreq0, oack0;
    logic [31:0]  odata0;
    logic [1:0]   och0;
    // DUT1: 3 lanes x 2 deep
    logic [2:0]   req1, ack1, full1, empty1;
    logic [95:0]  data1;
    logic         oreq1, oack1;
    logic [31:0]  odata1;
    logic [1:0]   och1;
    // DUT2: 1 lane x 2 deep
    logic [0:0]   req2, ack2, full2, empty2;
    logic [31:0]  data2;
    logic         oreq2, oack2;
    logic [31:0]  odata2;
    logic [0:0]   och2;

    noc_link_mux #(.n(32), .N_CH(4), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_req(req0), .in_ack(ack0), .in_data(data0),
        .out_req(oreq0), .out_ack(oack0), .out_data(odata0), .out_ch(och0),
        .lane_full(full0), .lane_empty(empty0));
    noc_link_mux #(.n(32), .N_CH(3), .DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_req(req1), .in_ack(ack1), .in_data(data1),
        .out_req(oreq1), .out_ack(oack1), .out_data(odata1), .out_ch(och1),
        .lane_full(full1), .lane_empty(empty1));
    noc_link_mux #(.n(32), .N_CH(1), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_req(req2), .in_ack(ack2), .in_data(data2),
        .out_req(oreq2), .out_ack(oack2), .out_data(odata2), .out_ch(och2),
        .lane_full(full2), .lane_empty(empty2));

    int unsigned nch [3] = '{4, 3, 1};
    int unsigned dep [3] = '{4, 2, 2};

    bit          d_req  [3][16];
    logic [31:0] d_data [3][16];
    bit          d_oack [3];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req0[i] = d_req[0][i];
            data0[i*32 +: 32] = d_data[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            req1[i] = d_req[1][i];
            data1[i*32 +: 32] = d_data[1][i];
        end
        req2[0] = d_req[2][0];
        data2   = d_data[2][0];
        oack0   = d_oack[0];
        oack1   = d_oack[1];
        oack2   = d_oack[2];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] obs_ack(int m);
        logic [15:0] v = '0;
        case (m)
            0: v[3:0] = ack0;
            1: v[2:0] = ack1;
            default: v[0] = ack2[0];
        endcase
        return v;
    endfunction

    function automatic logic [15:0] obs_full(int m);
        logic [15:0] v = '0;
        case (m)
            0: v[3:0] = full0;
            1: v[2:0] = full1;
            default: v[0] = full2[0];
        endcase
        return v;
    endfunction

    function automatic logic [15:0] obs_empty(int m);
        logic [15:0] v = '0;
        case (m)
            0: v[3:0] = empty0;
            1: v[2:0] = empty1;
            default: v[0] = empty2[0];
        endcase
        return v;
    endfunction

    function automatic logic obs_oreq(int m);
        return (m == 0) ? oreq0 : (m == 1) ? oreq1 : oreq2;
    endfunction

    function automatic logic [31:0] obs_odata(int m);
        return (m == 0) ? odata0 : (m == 1) ? odata1 : odata2;
    endfunction

    function automatic logic [3:0] obs_och(int m);
        return (m == 0) ? 4'(och0) : (m == 1) ? 4'(och1) : 4'(och2);
    endfunction

    function automatic logic ack_bit(int m, int i);
        logic [15:0] v = obs_ack(m);
        return v[i];
    endfunction

    // Reference model: per-lane word queues plus a three-phase output handshake.
    logic [31:0] mq [3][16][$];
    bit          m_ack   [3][16];
    bit          m_oreq  [3];
    logic [31:0] m_odata [3];
    int unsigned m_och   [3];
    int unsigned m_phase [3];   // 0 idle, 1 requesting, 2 releasing
    int unsigned m_ptr   [3];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 16; i++) begin
                mq[m][i].delete();
                m_ack[m][i] = 1'b0;
            end
            m_oreq[m] = 1'b0; m_odata[m] = '0; m_och[m] = 0;
            m_phase[m] = 0;   m_ptr[m] = 0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 3; m++) begin
            int unsigned cnt [16];
            int          pop_lane = -1;
            for (int i = 0; i < 16; i++) cnt[i] = mq[m][i].size();
            case (m_phase[m])
                0: begin
                    for (int k = 0; k < int'(nch[m]); k++) begin
                        int unsigned idx = (m_ptr[m] + k) % nch[m];
                        if (cnt[idx] > 0 && m_phase[m] == 0) begin
                            m_odata[m] = mq[m][idx][0];
                            m_och[m]   = idx;
                            m_oreq[m]  = 1'b1;
                            m_phase[m] = 1;
                        end
                    end
                end
                1: if (d_oack[m]) begin
                    pop_lane   = int'(m_och[m]);
                    m_oreq[m]  = 1'b0;
                    m_ptr[m]   = (m_och[m] + 1) % nch[m];
                    m_phase[m] = 2;
                end
                default: if (!d_oack[m]) m_phase[m] = 0;
            endcase
            for (int i = 0; i < int'(nch[m]); i++) begin
                if (d_req[m][i] && !m_ack[m][i] && cnt[i] < dep[m]) begin
                    mq[m][i].push_back(d_data[m][i]);
                    m_ack[m][i] = 1'b1;
                end else if (m_ack[m][i] && !d_req[m][i]) begin
                    m_ack[m][i] = 1'b0;
                end
            end
            if (pop_lane >= 0) void'(mq[m][pop_lane].pop_front());
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            logic [15:0] ea = '0, ef = '0, ee = '0;
            for (int i = 0; i < int'(nch[m]); i++) begin
                ea[i] = m_ack[m][i];
                ef[i] = (mq[m][i].size() == dep[m]);
                ee[i] = (mq[m][i].size() == 0);
            end
            check_eq($sformatf("in_ack%0d", m),     32'(obs_ack(m)),   32'(ea));
            check_eq($sformatf("lane_full%0d", m),  32'(obs_full(m)),  32'(ef));
            check_eq($sformatf("lane_empty%0d", m), 32'(obs_empty(m)), 32'(ee));
            check_eq($sformatf("out_req%0d", m),    32'(obs_oreq(m)),  32'(m_oreq[m]));
            check_eq($sformatf("out_data%0d", m),   obs_odata(m),      m_odata[m]);
            check_eq($sformatf("out_ch%0d", m),     32'(obs_och(m)),   m_och[m]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 16; i++) begin
                d_req[m][i] = 1'b0;
                d_data[m][i] = '0;
            end
            d_oack[m] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
    endtask

    task automatic send_word(int m, int lane, logic [31:0] w);
        d_data[m][lane] = w;
        d_req[m][lane]  = 1'b1;
        for (int k = 0; k < 30 && !ack_bit(m, lane); k++) cycle();
        check_eq("send_ack", 32'(ack_bit(m, lane)), 32'd1);
        d_req[m][lane] = 1'b0;
        for (int k = 0; k < 30 && ack_bit(m, lane); k++) cycle();
    endtask

    task automatic recv_one(int m, int exp_ch, logic [31:0] exp_data);
        for (int k = 0; k < 30 && !obs_oreq(m); k++) cycle();
        check_eq("recv_req", 32'(obs_oreq(m)), 32'd1);
        check_eq("recv_ch", 32'(obs_och(m)), 32'(exp_ch));
        check_eq("recv_data", obs_odata(m), exp_data);
        d_oack[m] = 1'b1;
        cycle();
        d_oack[m] = 1'b0;
        cycle();
    endtask

    task automatic auto_drive(int m, int ackp);
        for (int i = 0; i < int'(nch[m]); i++) begin
            logic a = ack_bit(m, i);
            if (!d_req[m][i] && !a && $urandom_range(2) == 0) begin
                d_data[m][i] = $urandom;
                d_req[m][i]  = 1'b1;
            end else if (d_req[m][i] && a && $urandom_range(1) == 0) begin
                d_req[m][i] = 1'b0;
            end
        end
        if (obs_oreq(m) && !d_oack[m] && int'($urandom_range(99)) < ackp) d_oack[m] = 1'b1;
        else if (!obs_oreq(m) && d_oack[m] && $urandom_range(1) == 0) d_oack[m] = 1'b0;
    endtask

    logic [31:0] bp_words [5] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333,
                                  32'h0000_4444, 32'h0000_5555};

    initial begin
        clear_inputs();
        #1 rst = 1'b0;
        #1;
        check_eq("rst_in_ack", 32'(ack0), 32'd0);
        check_eq("rst_out_req", 32'(oreq0), 32'd0);
        check_eq("rst_empty", 32'(empty0), 32'hF);
        do_reset();

        // Single word on lane 2
        d_data[0][2] = 32'hDEADBEEF;
        d_req[0][2]  = 1'b1;
        cycle();
        check_eq("single_ack", 32'(ack0[2]), 32'd1);
        check_eq("single_noreq", 32'(oreq0), 32'd0);
        d_req[0][2] = 1'b0;
        cycle();
        check_eq("single_req", 32'(oreq0), 32'd1);
        check_eq("single_data", odata0, 32'hDEADBEEF);
        check_eq("single_ch", 32'(och0), 32'd2);
        d_oack[0] = 1'b1;
        cycle();
        check_eq("single_empty", 32'(empty0[2]), 32'd1);
        d_oack[0] = 1'b0;
        cycle();

        // Backpressure on lane 0
        for (int k = 0; k < 4; k++) send_word(0, 0, bp_words[k]);
        check_eq("bp_full", 32'(full0[0]), 32'd1);
        d_data[0][0] = bp_words[4];
        d_req[0][0]  = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check_eq("bp_stall", 32'(ack0[0]), 32'd0);
        recv_one(0, 0, bp_words[0]);
        check_eq("bp_fifth_ack", 32'(ack0[0]), 32'd1);
        d_req[0][0] = 1'b0;
        cycle();
        for (int k = 1; k < 5; k++) recv_one(0, 0, bp_words[k]);
        check_eq("bp_drained", 32'(empty0[0]), 32'd1);

        // Round-robin with two words preloaded per lane
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                d_data[0][i] = 32'hA000_0000 | (i << 8) | k;
                d_req[0][i]  = 1'b1;
            end
            cycle();
            for (int i = 0; i < 4; i++) d_req[0][i] = 1'b0;
            cycle();
        end
        for (int j = 0; j < 8; j++) recv_one(0, j % 4, 32'hA000_0000 | ((j % 4) << 8) | (j / 4));

        // Reset while a transfer is pending
        for (int i = 0; i < 3; i++) begin
            d_data[0][i] = 32'hB000_0000 + i;
            d_req[0][i]  = 1'b1;
        end
        cycle();
        for (int i = 0; i < 3; i++) d_req[0][i] = 1'b0;
        cycle();
        cycle();
        check_eq("mid_req_pending", 32'(oreq0), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_req_drop", 32'(oreq0), 32'd0);
        check_eq("mid_empty", 32'(empty0), 32'hF);
        do_reset();
        send_word(0, 1, 32'h1234_5678);
        recv_one(0, 1, 32'h1234_5678);

        // Random traffic on all three configurations
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 3; m++) auto_drive(m, (c % 600 < 300) ? 15 : 70);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
